// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
//   Shared definitions for the bus arbiter and the bus masters around it:
//   - Enable_/Disable_ : active-low signal levels already used by the masters.
//   - ARB_IDLE/ARB_GRANT/ARB_RELEASE : 2-bit arbiter FSM state encodings.
//   - tenure_width() : width of the saturating tenure counter.
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    // Active-low request/grant/preempt levels.
    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;

    // Arbiter FSM states.
    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_GRANT   = 2'd1;
    localparam logic [1:0] ARB_RELEASE = 2'd2;

    // Tenure counter must hold 0..max_tenure; keep at least one bit so the
    // preemption-disabled configuration (max_tenure = 0) still elaborates.
    function automatic int tenure_width(int max_tenure);
        return (max_tenure < 1) ? 1 : $clog2(max_tenure + 1);
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
//   Bus-ownership handshake between NREQ bus masters and the arbiter.
//   Signals (all active-low vectors are one bit per master):
//     breq_     : master -> arbiter, bus request, low = requesting
//     prio_mode : master -> arbiter, 0 = fixed priority, 1 = round-robin
//     bgrt_     : arbiter -> master, bus grant, one-hot-low or all high
//     bpreempt_ : arbiter -> master, yield request, only the owner's bit low
//     bus_busy  : arbiter -> master, high while a grant is asserted
//     owner     : arbiter -> master, index of current or most recent owner
//
//   Handshake: a master holds breq_ low until it sees its bgrt_ low, then owns
//   the bus for as long as it keeps breq_ low. Raising breq_ is the only way
//   ownership ends; the arbiter never withdraws a grant on its own, and
//   bpreempt_ is only a hint to release soon. A master raising breq_ before it
//   has been granted simply withdraws the request.
// -----------------------------------------------------------------------------
interface bus_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) ();
    logic [NREQ-1:0] breq_;
    logic            prio_mode;
    logic [NREQ-1:0] bgrt_;
    logic [NREQ-1:0] bpreempt_;
    logic            bus_busy;
    logic [IDW-1:0]  owner;

    // Bus-master side.
    modport master (
        output breq_, prio_mode,
        input  bgrt_, bpreempt_, bus_busy, owner
    );

    // Arbiter side.
    modport slave (
        input  breq_, prio_mode,
        output bgrt_, bpreempt_, bus_busy, owner
    );
endinterface

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
//   Combinational winner selection. Searches the active-high request vector
//   starting at a base index and wrapping modulo NREQ; the first active
//   request found wins. Base is ptr_i in round-robin mode and 0 in fixed-
//   priority mode, so fixed priority is simply "lowest index wins".
//   Ports:
//     req_i   : NREQ active-high requests
//     ptr_i   : round-robin start index
//     rr_i    : 1 = round-robin, 0 = fixed priority
//     grant_o : one-hot winner (all zero when no request)
//     idx_o   : winner index (0 when no request)
//     valid_o : at least one request present
// -----------------------------------------------------------------------------
module arb_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            rr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            valid_o
);

    logic [IDW-1:0] base;
    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;

    assign base = rr_i ? ptr_i : '0;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            // base + i wraps at NREQ, which need not be a power of two.
            sum = {1'b0, base} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            cand = sum[IDW-1:0];
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Grants the shared bus to one of NREQ masters over the active-low
//   breq_/bgrt_ handshake, with fixed-priority or round-robin selection, one
//   RELEASE cycle between owners and a sticky yield hint (bpreempt_) for an
//   owner that has held the bus for MAX_TENURE cycles while others wait.
//   All outputs are registered.
//   Ports:
//     clk     : clock, rising edge
//     reset_  : asynchronous active-low reset
//     bus     : bus_arbiter_if.slave (breq_, prio_mode in; bgrt_, bpreempt_,
//               bus_busy, owner out)
//     state_o : current FSM state (ARB_IDLE/ARB_GRANT/ARB_RELEASE)
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int MAX_TENURE = 16,
    parameter int IDW        = $clog2(NREQ)
) (
    input  logic         clk,
    input  logic         reset_,
    bus_arbiter_if.slave bus,
    output logic [1:0]   state_o
);

    localparam int TW = tenure_width(MAX_TENURE);
    // Tenure counts grant cycles including the current one, so the grant edge
    // loads 1 for the first GRANT cycle.
    localparam logic [TW-1:0] TEN_START = (MAX_TENURE == 0) ? TW'(0) : TW'(1);

    logic [1:0]      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [TW-1:0]   ten_q, ten_d;
    logic [NREQ-1:0] bgrt_q, bgrt_d;
    logic [NREQ-1:0] bpre_q, bpre_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] req_act;
    logic [NREQ-1:0] win_oh;
    logic [IDW-1:0]  win_idx;
    logic            win_valid;

    assign req_act = ~bus.breq_;

    arb_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i   (req_act),
        .ptr_i   (ptr_q),
        .rr_i    (bus.prio_mode),
        .grant_o (win_oh),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    function automatic logic preempt_due(logic [TW-1:0] ten, logic others);
        return (MAX_TENURE != 0) && (int'(ten) >= MAX_TENURE) && others;
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        ten_d   = ten_q;
        bgrt_d  = bgrt_q;
        bpre_d  = bpre_q;
        busy_d  = busy_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_valid) begin
                    bgrt_d  = ~win_oh;
                    owner_d = win_idx;
                    busy_d  = 1'b1;
                    ten_d   = TEN_START;
                    ptr_d   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    bpre_d  = {NREQ{Disable_}};
                    if (preempt_due(TEN_START, |(req_act & ~win_oh))) begin
                        bpre_d[win_idx] = Enable_;
                    end
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (bus.breq_[owner_q] == Enable_) begin
                    ten_d = (int'(ten_q) < MAX_TENURE) ? ten_q + 1'b1 : ten_q;
                    // bgrt_q is high for every non-owner, so it masks the owner
                    // out of the "someone else is waiting" test. Preempt only
                    // ever sets here; it is cleared at release.
                    if (preempt_due(ten_d, |(req_act & bgrt_q))) begin
                        bpre_d[owner_q] = Enable_;
                    end
                end else begin
                    bgrt_d  = {NREQ{Disable_}};
                    bpre_d  = {NREQ{Disable_}};
                    busy_d  = 1'b0;
                    state_d = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                bgrt_d  = {NREQ{Disable_}};
                bpre_d  = {NREQ{Disable_}};
                busy_d  = 1'b0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            ten_q   <= '0;
            bgrt_q  <= {NREQ{Disable_}};
            bpre_q  <= {NREQ{Disable_}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            ten_q   <= ten_d;
            bgrt_q  <= bgrt_d;
            bpre_q  <= bpre_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.bgrt_     = bgrt_q;
    assign bus.bpreempt_ = bpre_q;
    assign bus.bus_busy  = busy_q;
    assign bus.owner     = owner_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//   Bench for bus_arbiter. dut_a runs with MAX_TENURE = 4, dut_b with
//   MAX_TENURE = 0. Expected owners for dut_a go into exp_q when a request is
//   driven; a monitor pops and checks them whenever a new grant appears.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_;
    always #5 clk = ~clk;

    bus_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus_a ();
    bus_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus_b ();
    logic [1:0] state_a;
    logic [1:0] state_b;

    bus_arbiter #(.NREQ(NREQ), .MAX_TENURE(4), .IDW(IDW)) dut_a (
        .clk     (clk),
        .reset_  (reset_),
        .bus     (bus_a.slave),
        .state_o (state_a)
    );

    bus_arbiter #(.NREQ(NREQ), .MAX_TENURE(0), .IDW(IDW)) dut_b (
        .clk     (clk),
        .reset_  (reset_),
        .bus     (bus_b.slave),
        .state_o (state_b)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [NREQ-1:0] prev_grt_a = '1;

    always @(negedge clk) begin
        logic [W-1:0]    e;
        logic [NREQ-1:0] oh;
        if (reset_ === 1'b1) begin
            total++;
            if ($countones(~bus_a.bgrt_) > 1 || bus_a.bus_busy !== (bus_a.bgrt_ != 4'hF)) begin
                bad++;
                $display("FAIL grant_shape: bgrt_=%b bus_busy=%b, need one-hot-low or all high with matching bus_busy",
                         bus_a.bgrt_, bus_a.bus_busy);
            end
            total++;
            if ((~bus_a.bpreempt_ & bus_a.bgrt_) !== 4'h0) begin
                bad++;
                $display("FAIL preempt_owner_only: bpreempt_=%b bgrt_=%b", bus_a.bpreempt_, bus_a.bgrt_);
            end
            if (bus_a.bgrt_ !== 4'hF && prev_grt_a === 4'hF) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_grant: bgrt_=%b with no grant expected", bus_a.bgrt_);
                end else begin
                    e  = exp_q.pop_front();
                    oh = 4'b0001 << e;
                    if (bus_a.bgrt_ !== ~oh || bus_a.owner !== e) begin
                        bad++;
                        $display("FAIL grant_order: bgrt_=%b owner=%0d expected bgrt_=%b owner=%0d",
                                 bus_a.bgrt_, bus_a.owner, ~oh, e);
                    end
                end
            end
        end
        prev_grt_a = bus_a.bgrt_;
    end

    // ---------------- driver helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [W-1:0] model_pick(input logic [3:0] req, input int ptr, input logic mode);
        int base;
        logic [W-1:0] c;
        base = mode ? ptr : 0;
        for (int i = 0; i < NREQ; i++) begin
            c = W'((base + i) % NREQ);
            if (req[c]) return c;
        end
        return '0;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        total++;
        if (bus_a.bgrt_ !== 4'hF) begin
            bad++; $display("FAIL reset_bgrt: got %b expected 1111", bus_a.bgrt_);
        end
        total++;
        if (bus_a.bpreempt_ !== 4'hF) begin
            bad++; $display("FAIL reset_bpreempt: got %b expected 1111", bus_a.bpreempt_);
        end
        total++;
        if (bus_a.bus_busy !== 1'b0 || bus_a.owner !== 2'd0) begin
            bad++; $display("FAIL reset_busy_owner: busy=%b owner=%0d expected 0/0", bus_a.bus_busy, bus_a.owner);
        end
        total++;
        if (state_a !== ARB_IDLE) begin
            bad++; $display("FAIL reset_state: got %0d expected %0d", state_a, ARB_IDLE);
        end
        reset_ = 1'b1;
        tick(2);
    endtask

    task automatic test_single();
        exp_q.push_back(2'd1);
        bus_a.breq_ = 4'b1101;
        #1;
        total++;
        if (bus_a.bgrt_ !== 4'hF) begin
            bad++; $display("FAIL single_no_comb_path: got %b expected 1111", bus_a.bgrt_);
        end
        tick(1);
        total++;
        if (bus_a.bgrt_ !== 4'b1101 || bus_a.bus_busy !== 1'b1 || bus_a.owner !== 2'd1) begin
            bad++; $display("FAIL single_grant: bgrt_=%b busy=%b owner=%0d expected 1101/1/1",
                            bus_a.bgrt_, bus_a.bus_busy, bus_a.owner);
        end
        for (int c = 0; c < 14; c++) begin
            tick(1);
            total++;
            if (bus_a.bgrt_ !== 4'b1101 || bus_a.bpreempt_ !== 4'hF) begin
                bad++; $display("FAIL single_hold: bgrt_=%b bpreempt_=%b expected 1101/1111", bus_a.bgrt_, bus_a.bpreempt_);
            end
        end
        bus_a.breq_ = 4'hF;
        tick(1);
        total++;
        if (bus_a.bgrt_ !== 4'hF || bus_a.bus_busy !== 1'b0 || state_a !== ARB_RELEASE) begin
            bad++; $display("FAIL single_release: bgrt_=%b busy=%b state=%0d expected 1111/0/%0d",
                            bus_a.bgrt_, bus_a.bus_busy, state_a, ARB_RELEASE);
        end
        tick(1);
        total++;
        if (state_a !== ARB_IDLE) begin
            bad++; $display("FAIL single_back_to_idle: state=%0d expected %0d", state_a, ARB_IDLE);
        end
    endtask

    task automatic test_fixed_priority();
        bus_a.prio_mode = 1'b0;
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        bus_a.breq_ = 4'b0011;
        tick(1);
        total++;
        if (bus_a.bgrt_ !== 4'b1011) begin
            bad++; $display("FAIL fixed_first: got %b expected 1011", bus_a.bgrt_);
        end
        tick(2);
        bus_a.breq_ = 4'b0111;   // master 2 releases, master 3 still waiting
        tick(1);
        total++;
        if (bus_a.bgrt_ !== 4'hF) begin
            bad++; $display("FAIL fixed_dead_1: got %b expected 1111", bus_a.bgrt_);
        end
        tick(1);
        total++;
        if (bus_a.bgrt_ !== 4'hF || state_a !== ARB_IDLE) begin
            bad++; $display("FAIL fixed_dead_2: bgrt_=%b state=%0d expected 1111/%0d", bus_a.bgrt_, state_a, ARB_IDLE);
        end
        tick(1);
        total++;
        if (bus_a.bgrt_ !== 4'b0111 || bus_a.owner !== 2'd3) begin
            bad++; $display("FAIL fixed_second: bgrt_=%b owner=%0d expected 0111/3", bus_a.bgrt_, bus_a.owner);
        end
        bus_a.breq_ = 4'hF;
        tick(3);
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5];
        logic [3:0] oh;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        bus_a.prio_mode = 1'b1;
        for (int k = 0; k < 5; k++) exp_q.push_back(order[k]);
        bus_a.breq_ = 4'b0000;
        tick(1);
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << order[k];
            total++;
            if (bus_a.bgrt_ !== ~oh || bus_a.owner !== order[k]) begin
                bad++; $display("FAIL rr_grant_%0d: bgrt_=%b owner=%0d expected %b/%0d",
                                k, bus_a.bgrt_, bus_a.owner, ~oh, order[k]);
            end
            tick(2);
            if (k == 4) bus_a.breq_ = 4'hF;
            else        bus_a.breq_[order[k]] = 1'b1;
            tick(1);
            if (k < 4) bus_a.breq_[order[k]] = 1'b0;   // rejoin the queue
            total++;
            if (bus_a.bgrt_ !== 4'hF) begin
                bad++; $display("FAIL rr_dead_a_%0d: got %b expected 1111", k, bus_a.bgrt_);
            end
            tick(1);
            total++;
            if (bus_a.bgrt_ !== 4'hF) begin
                bad++; $display("FAIL rr_dead_b_%0d: got %b expected 1111", k, bus_a.bgrt_);
            end
            tick(1);
        end
        tick(2);
    endtask

    task automatic test_preempt();
        bus_a.prio_mode = 1'b0;
        exp_q.push_back(2'd0);   // master 1 withdraws before it is served
        bus_a.breq_ = 4'b1100;
        for (int c = 1; c <= 3; c++) begin
            tick(1);
            total++;
            if (bus_a.bpreempt_ !== 4'hF) begin
                bad++; $display("FAIL preempt_early_c%0d: got %b expected 1111", c, bus_a.bpreempt_);
            end
        end
        tick(1);
        total++;
        if (bus_a.bpreempt_ !== 4'b1110) begin
            bad++; $display("FAIL preempt_c4: got %b expected 1110", bus_a.bpreempt_);
        end
        bus_a.breq_ = 4'b1110;
        for (int c = 5; c <= 6; c++) begin
            tick(1);
            total++;
            if (bus_a.bpreempt_ !== 4'b1110 || bus_a.bgrt_ !== 4'b1110) begin
                bad++; $display("FAIL preempt_sticky_c%0d: bpreempt_=%b bgrt_=%b expected 1110/1110",
                                c, bus_a.bpreempt_, bus_a.bgrt_);
            end
        end
        bus_a.breq_ = 4'hF;
        tick(1);
        total++;
        if (bus_a.bpreempt_ !== 4'hF || bus_a.bgrt_ !== 4'hF) begin
            bad++; $display("FAIL preempt_clear: bpreempt_=%b bgrt_=%b expected 1111/1111", bus_a.bpreempt_, bus_a.bgrt_);
        end
        tick(3);
        total++;
        if (bus_a.bgrt_ !== 4'hF || state_a !== ARB_IDLE) begin
            bad++; $display("FAIL withdrawn_ignored: bgrt_=%b state=%0d expected 1111/%0d", bus_a.bgrt_, state_a, ARB_IDLE);
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [1:0] owners [2];
        logic [3:0] oh;
        owners = '{2'd3, 2'd1};
        bus_a.prio_mode = 1'b1;
        for (int k = 0; k < 2; k++) begin
            oh = 4'b0001 << owners[k];
            exp_q.push_back(owners[k]);
            bus_a.breq_ = ~oh;
            tick(1);
            total++;
            if (bus_a.bgrt_ !== ~oh) begin
                bad++; $display("FAIL rst_pre_grant_%0d: got %b expected %b", k, bus_a.bgrt_, ~oh);
            end
            #2 reset_ = 1'b0;
            #1;
            total++;
            if (bus_a.bgrt_ !== 4'hF || bus_a.bus_busy !== 1'b0 || state_a !== ARB_IDLE) begin
                bad++; $display("FAIL rst_async_%0d: bgrt_=%b busy=%b state=%0d expected 1111/0/%0d",
                                k, bus_a.bgrt_, bus_a.bus_busy, state_a, ARB_IDLE);
            end
            bus_a.breq_ = 4'hF;
            tick(1);
            reset_ = 1'b1;
            tick(1);
            exp_q.push_back(2'd0);
            bus_a.breq_ = 4'b0000;
            tick(1);
            total++;
            if (bus_a.bgrt_ !== 4'b1110 || bus_a.owner !== 2'd0) begin
                bad++; $display("FAIL rst_ptr_zero_%0d: bgrt_=%b owner=%0d expected 1110/0", k, bus_a.bgrt_, bus_a.owner);
            end
            bus_a.breq_ = 4'hF;
            tick(3);
        end
    endtask

    task automatic test_random();
        int ptr_m;
        logic [3:0] req;
        logic mode;
        logic [W-1:0] e;
        bus_a.breq_ = 4'hF;
        reset_ = 1'b0;
        tick(1);
        reset_ = 1'b1;
        tick(1);
        ptr_m = 0;
        for (int n = 0; n < 20; n++) begin
            mode = 1'($urandom_range(0, 1));
            req  = 4'($urandom_range(1, 15));
            e    = model_pick(req, ptr_m, mode);
            ptr_m = (int'(e) + 1) % NREQ;
            exp_q.push_back(e);
            bus_a.prio_mode = mode;
            bus_a.breq_     = ~req;
            tick(1);
            total++;
            if (bus_a.owner !== e || bus_a.bus_busy !== 1'b1) begin
                bad++; $display("FAIL random_%0d: owner=%0d busy=%b expected %0d/1 (req=%b mode=%b)",
                                n, bus_a.owner, bus_a.bus_busy, e, req, mode);
            end
            tick($urandom_range(0, 5));
            bus_a.breq_ = 4'hF;
            tick(3);
        end
    endtask

    task automatic test_no_preempt();
        bus_b.prio_mode = 1'b0;
        bus_b.breq_ = 4'b0000;
        tick(1);
        total++;
        if (bus_b.bgrt_ !== 4'b1110) begin
            bad++; $display("FAIL nopre_grant: got %b expected 1110", bus_b.bgrt_);
        end
        for (int c = 0; c < 100; c++) begin
            tick(1);
            total++;
            if (bus_b.bpreempt_ !== 4'hF || bus_b.bgrt_ !== 4'b1110) begin
                bad++; $display("FAIL nopre_hold_c%0d: bpreempt_=%b bgrt_=%b expected 1111/1110",
                                c, bus_b.bpreempt_, bus_b.bgrt_);
            end
        end
        bus_b.breq_ = 4'hF;
        tick(1);
        total++;
        if (bus_b.bgrt_ !== 4'hF) begin
            bad++; $display("FAIL nopre_release: got %b expected 1111", bus_b.bgrt_);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset_ = 1'b0;
        bus_a.breq_ = 4'hF;
        bus_a.prio_mode = 1'b0;
        bus_b.breq_ = 4'hF;
        bus_b.prio_mode = 1'b0;
        tick(3);
        test_reset();
        test_single();
        test_fixed_priority();
        test_round_robin();
        test_preempt();
        test_reset_mid_grant();
        test_random();
        test_no_preempt();
        tick(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL exp_q_drained: %0d grants expected but never seen", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
